// File: rtl/dram_bank_model_if.sv
// Command/data bus between the SoC DRAM wrapper and the single-bank DRAM model.
// Handshake: a command is taken at every CK rising edge while CSn is low and is
// never back-pressured; VALID is a one-cycle strobe that qualifies Q.
interface dram_bank_model_if;
    logic        CSn;
    logic        RASn;
    logic        CASn;
    logic [3:0]  WEn;
    logic [10:0] A;
    logic [31:0] D;
    logic [31:0] Q;
    logic        VALID;

    modport master (output CSn, RASn, CASn, WEn, A, D, input Q, VALID);
    modport slave  (input CSn, RASn, CASn, WEn, A, D, output Q, VALID);
endinterface

// File: rtl/dram_bank_model.sv
// Behavioural single-bank DRAM: ACT/PRE/READ/WRITE decode, byte-lane writes and
// a CL-deep read pipeline. Storage lives in Memory_byte0..3 for backdoor access.
module dram_bank_model #(
    parameter int ROW_W = 11,
    parameter int COL_W = 10,
    parameter int CL    = 5
) (
    input  logic             CK,
    input  logic             RST,
    dram_bank_model_if.slave bus,
    output logic             dbg_state
);
    localparam int AW    = ROW_W + COL_W;
    localparam int DEPTH = 1 << AW;

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

    logic [7:0] Memory_byte0 [DEPTH];
    logic [7:0] Memory_byte1 [DEPTH];
    logic [7:0] Memory_byte2 [DEPTH];
    logic [7:0] Memory_byte3 [DEPTH];

    state_e            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [CL-1:0]     pv_q, pv_d;
    logic [31:0]       pd_q [CL];
    logic [31:0]       pd_d [CL];
    logic [31:0]       q_q, q_d;
    logic              valid_q, valid_d;

    logic              is_act, is_pre, is_rd, is_wr;
    logic              do_rd, do_wr;
    logic [AW-1:0]     word_addr;
    logic [31:0]       rd_word;

    always_comb begin
        is_act = !bus.CSn && !bus.RASn &&  bus.CASn && (bus.WEn == 4'hF);
        is_pre = !bus.CSn && !bus.RASn &&  bus.CASn && (bus.WEn == 4'h0);
        is_rd  = !bus.CSn &&  bus.RASn && !bus.CASn && (bus.WEn == 4'hF);
        is_wr  = !bus.CSn &&  bus.RASn && !bus.CASn && (bus.WEn != 4'hF);
        do_rd  = is_rd && (state_q == ACTIVE);
        do_wr  = is_wr && (state_q == ACTIVE);
        word_addr = {row_q, bus.A[COL_W-1:0]};
        // Storage is sampled at the command edge, so in-flight reads are immune to later writes.
        rd_word = {Memory_byte3[word_addr], Memory_byte2[word_addr],
                   Memory_byte1[word_addr], Memory_byte0[word_addr]};
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        case (state_q)
            IDLE: begin
                if (is_act) begin
                    state_d = ACTIVE;
                    row_d   = bus.A[ROW_W-1:0];
                end
            end
            ACTIVE: begin
                if (is_pre) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pv_d    = '0;
        pv_d[0] = do_rd;
        pd_d[0] = do_rd ? rd_word : pd_q[0];
        for (int i = 1; i < CL; i++) begin
            pv_d[i] = pv_q[i-1];
            pd_d[i] = pd_q[i-1];
        end
        valid_d = pv_q[CL-1];
        q_d     = pv_q[CL-1] ? pd_q[CL-1] : q_q;
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= IDLE;
            row_q   <= '0;
            pv_q    <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            pv_q    <= pv_d;
            q_q     <= q_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge CK) begin
        for (int i = 0; i < CL; i++) pd_q[i] <= pd_d[i];
    end

    always_ff @(posedge CK) begin
        if (!RST && do_wr) begin
            if (!bus.WEn[0]) Memory_byte0[word_addr] <= bus.D[7:0];
            if (!bus.WEn[1]) Memory_byte1[word_addr] <= bus.D[15:8];
            if (!bus.WEn[2]) Memory_byte2[word_addr] <= bus.D[23:16];
            if (!bus.WEn[3]) Memory_byte3[word_addr] <= bus.D[31:24];
        end
    end

    assign bus.Q     = q_q;
    assign bus.VALID = valid_q;
    assign dbg_state = (state_q == ACTIVE);
endmodule

// File: tb/tb_dram_bank_model.sv
// Bench for dram_bank_model: directed scenarios plus random command traffic,
// checked every cycle against a queue-based reference model.
module tb_dram_bank_model;
    localparam int CL = 5;

    // clock / reset
    logic CK = 1'b0;
    logic RST;
    always #5 CK = ~CK;

    dram_bank_model_if bus();
    logic dbg_state;

    dram_bank_model #(.ROW_W(11), .COL_W(10), .CL(CL)) dut (
        .CK(CK), .RST(RST), .bus(bus), .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model: word store, open-row flag, expected read results with due cycle
    logic [31:0] mem_m [int];
    logic        m_open = 1'b0;
    logic [10:0] m_row  = '0;
    logic [31:0] m_q    = '0;
    logic        m_started = 1'b0;
    logic [31:0] exp_q [$];
    int          due_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %08h want %08h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive(input logic csn, input logic rasn, input logic casn,
                         input logic [3:0] wen, input logic [10:0] a, input logic [31:0] d);
        bus.CSn = csn; bus.RASn = rasn; bus.CASn = casn;
        bus.WEn = wen; bus.A = a; bus.D = d;
    endtask

    task automatic preload(input int addr, input logic [31:0] w);
        dut.Memory_byte0[addr] = w[7:0];
        dut.Memory_byte1[addr] = w[15:8];
        dut.Memory_byte2[addr] = w[23:16];
        dut.Memory_byte3[addr] = w[31:24];
        mem_m[addr] = w;
    endtask

    function automatic logic [31:0] peek(input int addr);
        return {dut.Memory_byte3[addr], dut.Memory_byte2[addr],
                dut.Memory_byte1[addr], dut.Memory_byte0[addr]};
    endfunction

    task automatic model_edge();
        int addr;
        logic [31:0] w;
        if (RST) begin
            m_open = 1'b0;
            m_q = '0;
            m_started = 1'b1;
            exp_q.delete();
            due_q.delete();
        end else if (!bus.CSn) begin
            addr = int'({m_row, bus.A[9:0]});
            if (!bus.RASn && bus.CASn && bus.WEn == 4'hF) begin
                if (!m_open) begin m_open = 1'b1; m_row = bus.A; end
            end else if (!bus.RASn && bus.CASn && bus.WEn == 4'h0) begin
                m_open = 1'b0;
            end else if (bus.RASn && !bus.CASn && m_open) begin
                w = mem_m.exists(addr) ? mem_m[addr] : 32'h0;
                if (bus.WEn == 4'hF) begin
                    exp_q.push_back(w);
                    due_q.push_back(cyc + CL);
                end else begin
                    for (int i = 0; i < 4; i++)
                        if (!bus.WEn[i]) w[8*i +: 8] = bus.D[8*i +: 8];
                    mem_m[addr] = w;
                end
            end
        end
    endtask

    task automatic step();
        logic exp_v;
        @(posedge CK);
        cyc++;
        model_edge();
        #1;
        if (m_started) begin
            exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
            if (exp_v) begin
                m_q = exp_q.pop_front();
                void'(due_q.pop_front());
            end
            chk("valid", {31'b0, bus.VALID}, {31'b0, exp_v});
            chk("q", bus.Q, m_q);
            chk("state", {31'b0, dbg_state}, {31'b0, m_open});
        end
    endtask

    task automatic nops(input int n);
        drive(1'b1, 1'b1, 1'b1, 4'hF, '0, '0);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic act(input logic [10:0] row);  drive(1'b0, 1'b0, 1'b1, 4'hF, row, '0); step(); endtask
    task automatic pre();                        drive(1'b0, 1'b0, 1'b1, 4'h0, '0, '0);  step(); endtask
    task automatic rd(input logic [10:0] col);   drive(1'b0, 1'b1, 1'b0, 4'hF, col, '0); step(); endtask
    task automatic wr(input logic [10:0] col, input logic [3:0] wen, input logic [31:0] d);
        drive(1'b0, 1'b1, 1'b0, wen, col, d); step();
    endtask

    initial begin
        logic [3:0]  wen;
        logic [10:0] a;
        logic [10:0] rows [2];
        rows[0] = 11'h100;
        rows[1] = 11'h2AB;

        // reset then idle
        RST = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 4'hF, '0, '0);
        step(); step();
        RST = 1'b0;
        nops(4);

        // full write/read
        preload(32'h40004, 32'h0);
        act(11'h100);
        wr(11'h004, 4'h0, 32'hDEADBEEF);
        rd(11'h004);
        nops(CL + 1);
        chk("backdoor_write", peek(32'h40004), 32'hDEADBEEF);

        // byte masking
        preload(32'h40008, 32'h12345678);
        wr(11'h008, 4'b1010, 32'hAABBCCDD);
        rd(11'h008);
        nops(CL + 1);
        chk("byte_mask", peek(32'h40008), 32'h12BB56DD);

        // burst of four reads
        preload(32'h40000, 32'h11);
        preload(32'h40001, 32'h22);
        preload(32'h40002, 32'h33);
        preload(32'h40003, 32'h44);
        for (int i = 0; i < 4; i++) rd(11'(i));
        nops(CL + 1);

        // write after read in flight must not change captured data
        rd(11'h001);
        wr(11'h001, 4'h0, 32'hCAFEF00D);
        nops(CL + 1);

        // ignored commands
        pre();
        rd(11'h000);
        nops(CL + 1);
        preload(32'h80000, 32'h99999999);
        act(11'h100);
        act(11'h200);
        rd(11'h000);
        nops(CL + 1);
        pre();
        rd(11'h000);
        nops(CL + 1);

        // reset mid-read
        act(11'h100);
        rd(11'h002);
        nops(1);
        RST = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 4'hF, 11'h003, '0);
        step(); step();
        RST = 1'b0;
        nops(CL + 1);
        act(11'h100);
        rd(11'h003);
        nops(CL + 1);

        // random traffic over two rows, cols 0..7 (A[10] toggled as a don't-care)
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 8; c++)
                preload(int'({rows[r], 10'(c)}), $urandom());
        pre();
        for (int n = 0; n < 600; n++) begin
            a = {1'($urandom_range(0, 1)), 7'b0, 3'($urandom_range(0, 7))};
            RST = ($urandom_range(0, 79) == 0);
            case ($urandom_range(0, 9))
                0:       drive(1'b0, 1'b0, 1'b1, 4'hF, rows[$urandom_range(0, 1)], $urandom());
                1:       drive(1'b0, 1'b0, 1'b1, 4'h0, a, $urandom());
                2, 3, 4: drive(1'b0, 1'b1, 1'b0, 4'hF, a, $urandom());
                5, 6: begin
                    wen = 4'($urandom_range(0, 14));
                    drive(1'b0, 1'b1, 1'b0, wen, a, $urandom());
                end
                7: begin
                    wen = 4'($urandom_range(1, 14));
                    drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), wen, a, $urandom());
                end
                8:       drive(1'b0, 1'b1, 1'b1, 4'($urandom()), a, $urandom());
                default: drive(1'b1, 1'($urandom()), 1'($urandom()), 4'($urandom()), a, $urandom());
            endcase
            step();
        end
        RST = 1'b0;
        nops(CL + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
